// File: rtl/laplace_stream_filter.sv
// laplace_stream_filter: streaming 4-neighbour Laplacian (b+d+f+h-4e) with internal line buffers,
// two-stage pipeline and per-frame approximate b+d adder.
module laplace_stream_filter #(
  parameter int PIX_W       = 8,
  parameter int IMG_W       = 640,
  parameter int IMG_H       = 480,
  parameter int APPROX_BITS = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [PIX_W-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_sof,
  input  logic             approx_en,
  output logic [PIX_W-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_last
);
  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam logic [PIX_W:0] LO_M = (PIX_W+1)'((1 << APPROX_BITS) - 1);
  localparam logic signed [PIX_W+2:0] MAX_V = (PIX_W+3)'((1 << PIX_W) - 1);
  logic [CW-1:0] c_q, c_pos, c_d;
  logic [RW-1:0] r_q, r_pos, r_d;
  logic c_end, r_end, adv, acc, mode_q, mode_pix;
  logic [PIX_W-1:0] lb1_q [IMG_W];
  logic [PIX_W-1:0] lb2_q [IMG_W];
  logic [PIX_W-1:0] lb1_rd, lb2_rd;
  logic [PIX_W-1:0] f1_q, f2_q, t1_q, h1_q;
  logic [PIX_W-1:0] b_q, d_q, e_q, f_q, h_q;
  logic a_valid_q, a_last_q, a_mode_q;
  logic [PIX_W-1:0] out_data_q, clamp_d;
  logic out_valid_q, out_last_q;
  logic [PIX_W:0] s1_ex, s1_ap, sum1, sum2;
  logic [PIX_W+1:0] sum3;
  logic signed [PIX_W+2:0] lap;
  assign adv      = !out_valid_q || out_ready;
  assign in_ready = adv;
  assign acc      = in_valid && adv;
  // in_sof overrides the counters so a stray stream resynchronises at (0,0)
  assign c_pos    = in_sof ? '0 : c_q;
  assign r_pos    = in_sof ? '0 : r_q;
  assign c_end    = c_pos == CW'(IMG_W - 1);
  assign r_end    = r_pos == RW'(IMG_H - 1);
  assign c_d      = c_end ? '0 : c_pos + 1'b1;
  assign r_d      = c_end ? (r_end ? '0 : r_pos + 1'b1) : r_pos;
  assign mode_pix = (c_pos == '0 && r_pos == '0) ? approx_en : mode_q;
  assign lb1_rd   = lb1_q[c_pos];
  assign lb2_rd   = lb2_q[c_pos];
  always_ff @(posedge clk)
    if (!rst && acc) begin
      lb2_q[c_pos] <= lb1_rd;
      lb1_q[c_pos] <= in_data;
    end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_q         <= '0;
      c_q         <= '0;
      mode_q      <= 1'b0;
      a_valid_q   <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
    end else if (adv) begin
      if (acc) begin
        r_q    <= r_d;
        c_q    <= c_d;
        mode_q <= mode_pix;
        t1_q   <= lb2_rd;
        f1_q   <= lb1_rd;
        f2_q   <= f1_q;
        h1_q   <= in_data;
      end
      a_valid_q   <= acc && r_pos >= RW'(2) && c_pos >= CW'(2);
      a_last_q    <= r_end && c_end;
      a_mode_q    <= mode_pix;
      b_q         <= t1_q;
      d_q         <= f2_q;
      e_q         <= f1_q;
      f_q         <= lb1_rd;
      h_q         <= h1_q;
      out_valid_q <= a_valid_q;
      out_last_q  <= a_valid_q && a_last_q;
      if (a_valid_q) out_data_q <= clamp_d;
    end
  end
  // masked upper add has zero low bits, so no carry leaks in from the OR-ed LSBs
  assign s1_ex   = {1'b0, b_q} + {1'b0, d_q};
  assign s1_ap   = (({1'b0, b_q} & ~LO_M) + ({1'b0, d_q} & ~LO_M)) | (({1'b0, b_q} | {1'b0, d_q}) & LO_M);
  assign sum1    = a_mode_q ? s1_ap : s1_ex;
  assign sum2    = {1'b0, f_q} + {1'b0, h_q};
  assign sum3    = {1'b0, sum1} + {1'b0, sum2};
  assign lap     = $signed({1'b0, sum3}) - $signed({1'b0, e_q, 2'b00});
  assign clamp_d = (lap < 0) ? '0 : (lap > MAX_V) ? '1 : lap[PIX_W-1:0];
  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
endmodule

// File: tb/tb_laplace_stream_filter.sv
// tb_laplace_stream_filter: directed frames on a 4x4 image with hand-computed Laplacian outputs.
module tb_laplace_stream_filter;
  logic clk = 1'b0;
  logic rst, in_valid, in_ready, in_sof, approx_en, out_valid, out_ready, out_last;
  logic [7:0] in_data, out_data;
  int n_tests = 0;
  int n_fail = 0;
  logic [7:0] frame [16];
  logic [8:0] outs [$];
  int n_acc, first_acc;
  laplace_stream_filter #(.PIX_W(8), .IMG_W(4), .IMG_H(4), .APPROX_BITS(2)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .in_sof(in_sof), .approx_en(approx_en), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_last(out_last)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic tick(output bit a);
    #1;
    if (out_valid && out_ready) begin
      if (outs.size() == 0) first_acc = n_acc;
      outs.push_back({out_last, out_data});
    end
    a = in_valid && in_ready;
    if (a) n_acc++;
    @(posedge clk);
    @(negedge clk);
  endtask
  task automatic fill(input logic [7:0] v);
    for (int i = 0; i < 16; i++) frame[i] = v;
  endtask
  task automatic set_ramp();
    fill(8'd0);
    frame[1] = 8'd10; frame[2] = 8'd20; frame[4] = 8'd30; frame[8] = 8'd40;
    frame[7] = 8'd50; frame[11] = 8'd60; frame[13] = 8'd70; frame[14] = 8'd80;
  endtask
  task automatic stream(input int n, input bit sof0, input bit ap0, input bit ap_rest,
                        input int stall, input logic [7:0] stall_data);
    int idx;
    int budget;
    bit stalled;
    bit a;
    idx = 0; budget = 0; stalled = 0;
    n_acc = 0; first_acc = -1; outs.delete();
    while (idx < n && budget < 200) begin
      in_data = frame[idx]; in_valid = 1'b1; in_sof = sof0 && idx == 0;
      approx_en = idx == 0 ? ap0 : ap_rest;
      if (stall > 0 && !stalled && out_valid) begin
        stalled = 1;
        out_ready = 1'b0;
        for (int k = 0; k < stall; k++) begin
          #1;
          check("bp_in_ready", in_ready, 0);
          check("bp_out_valid", out_valid, 1);
          check("bp_out_data", out_data, stall_data);
          check("bp_out_last", out_last, 0);
          tick(a);
          if (a) idx++;
        end
        out_ready = 1'b1;
      end
      tick(a);
      if (a) idx++;
      budget++;
    end
    check("stream_timeout", budget < 200, 1);
    in_valid = 1'b0; in_sof = 1'b0;
    repeat (8) tick(a);
  endtask
  task automatic expect4(input string tag, input int e0, input int e1, input int e2, input int e3);
    int e [4];
    logic [8:0] v;
    e = '{e0, e1, e2, e3};
    check({tag, "_count"}, outs.size(), 4);
    for (int i = 0; i < 4; i++) begin
      v = i < outs.size() ? outs[i] : 9'h1FF;
      check({tag, "_data"}, v[7:0], e[i]);
      check({tag, "_last"}, v[8], i == 3);
    end
  endtask
  initial begin
    rst = 1'b1; in_valid = 1'b0; in_sof = 1'b0; approx_en = 1'b0; out_ready = 1'b1; in_data = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_last", out_last, 0);
    check("rst_in_ready", in_ready, 1);
    @(negedge clk);
    fill(8'd100);
    stream(16, 1, 0, 0, 0, 0);
    expect4("flat", 0, 0, 0, 0);
    check("flat_latency", first_acc, 12);
    fill(8'd255); frame[5] = 8'd0;
    stream(16, 1, 0, 0, 0, 0);
    expect4("pos_clamp", 255, 0, 0, 0);
    fill(8'd0); frame[5] = 8'd255;
    stream(16, 1, 0, 0, 0, 0);
    expect4("neg_clamp", 0, 255, 255, 0);
    fill(8'd0); frame[1] = 8'd3; frame[4] = 8'd1;
    stream(16, 1, 1, 1, 0, 0);
    expect4("approx", 3, 0, 0, 0);
    stream(16, 1, 0, 0, 0, 0);
    expect4("exact", 4, 0, 0, 0);
    stream(16, 1, 1, 0, 0, 0);
    expect4("approx_toggle", 3, 0, 0, 0);
    stream(16, 1, 0, 1, 0, 0);
    expect4("exact_toggle", 4, 0, 0, 0);
    set_ramp();
    stream(16, 1, 0, 0, 0, 0);
    expect4("ramp", 40, 70, 110, 140);
    stream(16, 1, 0, 0, 5, 8'd40);
    expect4("backpressure", 40, 70, 110, 140);
    fill(8'd255);
    stream(6, 1, 0, 0, 0, 0);
    check("partial_no_out", outs.size(), 0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    set_ramp();
    stream(16, 0, 0, 0, 0, 0);
    expect4("after_reset", 40, 70, 110, 140);
    check("after_reset_latency", first_acc, 12);
    fill(8'd255);
    stream(6, 1, 0, 0, 0, 0);
    set_ramp();
    stream(16, 1, 0, 0, 0, 0);
    expect4("sof_resync", 40, 70, 110, 140);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/laplace_stream_filter.md
# laplace_stream_filter

Streaming 4-neighbour Laplacian filter for raster-order pixel streams. It computes s = b + d + f + h − 4e over a cross window. The window is built internally from two line buffers, so no external window fetch is needed. Pixel width, image size and approximate-adder depth are parameters, and the mode is selectable per frame. It sits between the pixel source and the edge-map sink in the image pipeline, with valid/ready handshakes on both sides.

## Interface

Parameters:
- PIX_W, 8: pixel width in bits.
- IMG_W, 640: pixels per row (≥ 3).
- IMG_H, 480: rows per frame (≥ 3).
- APPROX_BITS, 2: LSBs of the b + d adder computed approximately (0 ≤ APPROX_BITS < PIX_W).

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  synchronous active-high reset.
- in_data  in  PIX_W  input pixel.
- in_valid  in  1  input pixel present.
- in_ready  out  1  filter accepts input this cycle.
- in_sof  in  1  the accepted pixel is pixel (0,0) of a new frame.
- approx_en  in  1  approximate-mode request, sampled at frame start.
- out_data  out  PIX_W  clamped Laplacian of one interior pixel.
- out_valid  out  1  out_data valid.
- out_ready  in  1  sink accepts out_data.
- out_last  out  1  marks the last interior pixel of the frame.

## Operation

**Input side**
- An input is accepted on a cycle where in_valid && in_ready.
- Row and column counters (r, c) track the accepted pixel position.
  - c wraps at IMG_W−1 and increments r.
  - r wraps at IMG_H−1 back to (0,0).
- If in_sof is high on an accepted pixel, that pixel is forced to (0,0), whatever the counters hold. This resynchronises the frame.

**Window construction**
- Two line buffers of IMG_W entries each hold rows r−1 and r−2.
- Together with two column-delay registers they form the window for accepted pixel (r,c):
  - b = (r−2, c−1)
  - d = (r−1, c−2)
  - e = (r−1, c−1)
  - f = (r−1, c)
  - h = (r, c−1)

**Output selection**
- An output is produced only when r ≥ 2 and c ≥ 2, i.e. centre (r−1, c−1) is an interior pixel.
- Each frame therefore yields exactly (IMG_H−2)·(IMG_W−2) outputs in raster order. Border pixels produce nothing.
- out_last is high with the output whose centre is (IMG_H−2, IMG_W−2).

**Mode**
- approx_en is latched into a mode register when pixel (0,0) is accepted.
- That value holds for the whole frame; changes mid-frame have no effect until the next (0,0).

**Arithmetic**
- sum1 (PIX_W+1 bits) = b + d:
  - Exact mode: normal addition.
  - Approximate mode, bits i < APPROX_BITS: sum1[i] = b[i] | d[i].
  - Approximate mode, upper bits: b[PIX_W−1:APPROX_BITS] + d[PIX_W−1:APPROX_BITS], exact, with carry-in 0.
  - APPROX_BITS = 0 makes both modes identical.
- sum2 (PIX_W+1 bits) = f + h, always exact.
- sum3 (PIX_W+2 bits) = sum1 + sum2, exact.
- lap (PIX_W+3 bits, signed) = sum3 − 4e. Both operands are zero-extended before the subtraction.
- Clamp:
  - lap < 0 → out_data = 0.
  - lap > 2^PIX_W − 1 → out_data = 2^PIX_W − 1.
  - Otherwise out_data = lap[PIX_W−1:0].
- The sign test is a true signed comparison.

## Timing

**Pipeline**
- Two stages:
  - Stage A registers the window and a valid flag.
  - Stage B computes, clamps and registers out_data, out_valid and out_last.
- Advance enable: adv = !out_valid || out_ready.
- in_ready = adv, combinational from out_valid and out_ready; it has no dependence on in_valid.

**Latency**
- An accepted qualifying pixel appears at out_valid 2 cycles later when there is no stall.
- Throughput is 1 pixel/cycle.

**Backpressure**
- While out_valid && !out_ready:
  - out_data and out_last hold stable.
  - in_ready = 0.
  - No state advances: counters, line buffers and stage A are all frozen.

**Reset values**
- out_valid = 0, out_data = 0, out_last = 0.
- Counters at (0,0); stage A valid = 0; mode register = 0 (exact).
- Line-buffer contents need not be cleared: no output is produced until rows 0 and 1 of the new frame are rewritten.
- Reset mid-frame drops any pending output. The next accepted pixel is treated as (0,0).

**Simultaneous events**
- in_sof on pixel (r,c) while an output is pending in stage B: the pending output completes normally.
- The new frame's first output appears only after its pixel (2,2) is accepted.

## Test plan

Bench parameters: IMG_W = IMG_H = 4, PIX_W = 8, APPROX_BITS = 2 unless stated.

1. **Flat frame:** all 16 pixels = 100, exact mode → exactly 4 outputs, each 0; out_last on the 4th only.
2. **Positive clamp:** centre (1,1) = 0, all other pixels = 255 → output for (1,1) = 255.
3. **Negative clamp:** centre (1,1) = 255, all other pixels = 0 → output for (1,1) = 0.
4. **Approximate vs exact:** b = 3, d = 1, f = h = e = 0 around centre (1,1).
   - Frame with approx_en = 1 → output 3.
   - Repeat frame with approx_en = 0 → output 4.
   - Toggling approx_en mid-frame leaves that frame's results unchanged.
5. **Backpressure:** hold out_ready = 0 for 5 cycles while out_valid = 1.
   - out_data and out_last stay stable; in_ready = 0.
   - After release, all 4 outputs arrive in order, none lost or duplicated.
6. **Reset and resync:**
   - Assert rst after 6 pixels, then stream a full frame → exactly 4 correct outputs, first after the new pixel (2,2).
   - Separately, in_sof asserted mid-frame restarts the counters to (0,0).
